// File: rtl/dbgnoc_out_arbiter.sv
// dbgnoc_out_arbiter: packet-level round-robin arbiter sharing one debug-NoC output
// link among NUM_PORTS flit sources. A grant covers a whole packet and is released
// when its LAST/SINGLE flit is accepted. The output is a single register slice.
//
// Flit layout (FW = noc_data_width + noc_type_width): {type, data}, type in the MSBs.
// Type bits [1:0]: 01 HEADER, 00 PAYLOAD, 10 LAST, 11 SINGLE.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   in_flit      flattened input flits, port i at [i*FW +: FW]
//   in_valid     per-port flit valid
//   in_ready     per-port flit accepted (combinational from state and out_ready)
//   out_flit     registered output flit
//   out_valid    registered output valid
//   out_ready    downstream accepts out_flit
//   grant_port   currently granted port, meaningful while busy=1
//   busy         a packet is in progress
//   pkt_count    packets forwarded, counted when LAST/SINGLE is accepted (wraps)
module dbgnoc_out_arbiter #(
    parameter int unsigned noc_data_width = 16,
    parameter int unsigned noc_type_width = 2,
    parameter int unsigned NUM_PORTS      = 4
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic [NUM_PORTS*(noc_data_width+noc_type_width)-1:0] in_flit,
    input  logic [NUM_PORTS-1:0]                                in_valid,
    output logic [NUM_PORTS-1:0]                                in_ready,
    output logic [noc_data_width+noc_type_width-1:0]            out_flit,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [$clog2(NUM_PORTS)-1:0]                        grant_port,
    output logic                                                busy,
    output logic [15:0]                                         pkt_count
);

    localparam int unsigned FW       = noc_data_width + noc_type_width;
    localparam int unsigned PW       = $clog2(NUM_PORTS);
    // Type bit 1 is set for both LAST and SINGLE: the packet-ending flits.
    localparam int unsigned END_BIT  = noc_data_width + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]     pkt_count_q, pkt_count_d;
    logic [FW-1:0]   out_flit_q, out_flit_d;
    logic            out_valid_q, out_valid_d;

    logic [PW-1:0]   rr_pick;
    logic            rr_found;
    logic [FW-1:0]   sel_flit;
    logic            sel_valid;
    logic            slot_free;
    logic            in_xfer;
    logic [PW-1:0]   grant_next;

    // First valid port searching from rr_ptr upwards, wrapping modulo NUM_PORTS.
    always_comb begin
        int unsigned idx;
        logic [PW-1:0] idx_w;
        rr_pick  = rr_ptr_q;
        rr_found = 1'b0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx   = (32'(rr_ptr_q) + k) % NUM_PORTS;
            idx_w = PW'(idx);
            if (!rr_found && in_valid[idx_w]) begin
                rr_found = 1'b1;
                rr_pick  = idx_w;
            end
        end
    end

    assign sel_flit   = in_flit[grant_q*FW +: FW];
    assign sel_valid  = in_valid[grant_q];
    assign slot_free  = !out_valid_q || out_ready;
    assign in_xfer    = (state_q == ST_BUSY) && slot_free && sel_valid;
    assign grant_next = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + PW'(1);

    // Only the granted port may see ready, and only while the slice can take a flit.
    always_comb begin
        in_ready = '0;
        if (state_q == ST_BUSY) begin
            in_ready[grant_q] = slot_free;
        end
    end

    // Next-state logic: arbitration in IDLE, flit forwarding in BUSY.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        pkt_count_d = pkt_count_q;
        out_flit_d  = out_flit_q;
        out_valid_d = out_valid_q;

        // Drain first; a simultaneous load below overrides this.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_xfer) begin
                    out_flit_d  = sel_flit;
                    out_valid_d = 1'b1;
                    if (sel_flit[END_BIT]) begin
                        state_d     = ST_IDLE;
                        rr_ptr_d    = grant_next;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            pkt_count_q <= '0;
            out_flit_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            pkt_count_q <= pkt_count_d;
            out_flit_q  <= out_flit_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_flit   = out_flit_q;
    assign out_valid  = out_valid_q;
    assign grant_port = grant_q;
    assign busy       = (state_q == ST_BUSY);
    assign pkt_count  = pkt_count_q;

endmodule
